// File: rtl/dtcore32_wb_arbiter.sv
// dtcore32_wb_arbiter: regfile write-port arbiter for the dtcore32 pipeline.
// In-order pipeline writeback always wins the single write port. Long-latency
// (mul/div) results queue in a small FIFO and drain on free cycles.
// Optional starvation guard: define DTCORE32_WB_STARVE_GUARD_EN to enable it.
// When enabled, a FIFO head that waits MAX_WAIT cycles raises pipe_stall_o.
// That stall holds the pipeline off until the head is written.
module dtcore32_wb_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       pipe_wb_valid_i,
   input  logic [4:0]                 pipe_wb_rd_i,
   input  logic [31:0]                pipe_wb_data_i,
   input  logic                       lu_valid_i,
   output logic                       lu_ready_o,
   input  logic [4:0]                 lu_rd_i,
   input  logic [31:0]                lu_data_i,
   output logic                       regfile_wr_en_o,
   output logic [4:0]                 dest_reg_o,
   output logic [31:0]                reg_wr_data_o,
   output logic [31:0]                pending_mask_o,
   output logic [$clog2(DEPTH):0]     fifo_count_o,
   output logic                       pipe_stall_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]     rd_q   [DEPTH];
   logic [31:0]    data_q [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           push, pop, pipe_sel, fifo_empty, stall;

   assign fifo_empty   = (count == '0);
   assign lu_ready_o   = (count != CW'(DEPTH));
   assign fifo_count_o = count;
   // x0 results complete the handshake but are never stored
   assign push         = lu_valid_i && lu_ready_o && (lu_rd_i != 5'd0);
   // pipeline writes to x0 are dropped and leave the port free for the FIFO
   assign pipe_sel     = pipe_wb_valid_i && (pipe_wb_rd_i != 5'd0) && !stall;
   assign pop          = !pipe_sel && !fifo_empty;

   // FIFO payload storage; no reset needed, validity is tracked separately
   always_ff @(posedge clk_i) begin
      if (push) begin
         rd_q[wr_ptr]   <= lu_rd_i;
         data_q[wr_ptr] <= lu_data_i;
      end
   end

   // FIFO pointers, occupancy and per-entry valid bits
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // pending-destination mask for decode hazard checks
   always_comb begin
      pending_mask_o = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i]) pending_mask_o[rd_q[i]] = 1'b1;
      pending_mask_o[0] = 1'b0;
   end

   // registered regfile write port; idle cycles hold rd/data
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         regfile_wr_en_o <= 1'b0;
         dest_reg_o      <= '0;
         reg_wr_data_o   <= '0;
      end else if (pipe_sel) begin
         regfile_wr_en_o <= 1'b1;
         dest_reg_o      <= pipe_wb_rd_i;
         reg_wr_data_o   <= pipe_wb_data_i;
      end else if (pop) begin
         regfile_wr_en_o <= 1'b1;
         dest_reg_o      <= rd_q[rd_ptr];
         reg_wr_data_o   <= data_q[rd_ptr];
      end else begin
         regfile_wr_en_o <= 1'b0;
      end
   end

`ifdef DTCORE32_WB_STARVE_GUARD_EN
   localparam int WW = $clog2(MAX_WAIT + 1);
   logic [WW-1:0] wait_cnt;

   // count cycles the head is denied; raise stall at threshold until a pop
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wait_cnt <= '0;
         stall    <= 1'b0;
      end else if (pop || fifo_empty) begin
         wait_cnt <= '0;
         stall    <= 1'b0;
      end else begin
         if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
         else                           stall    <= 1'b1;
      end
   end

   // the pipeline must honour the stall request
   always_ff @(posedge clk_i) begin
      if (rst_ni && stall)
         assert (!pipe_wb_valid_i) else $error("pipe writeback while stalled");
   end
`else
   assign stall = 1'b0;
`endif

   assign pipe_stall_o = stall;

endmodule

// File: tb/tb_dtcore32_wb_arbiter.sv
// Directed bench for dtcore32_wb_arbiter (default build, starvation guard off).
module tb_dtcore32_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        pipe_wb_valid_i;
   logic [4:0]  pipe_wb_rd_i;
   logic [31:0] pipe_wb_data_i;
   logic        lu_valid_i;
   logic        lu_ready_o;
   logic [4:0]  lu_rd_i;
   logic [31:0] lu_data_i;
   logic        regfile_wr_en_o;
   logic [4:0]  dest_reg_o;
   logic [31:0] reg_wr_data_o;
   logic [31:0] pending_mask_o;
   logic [2:0]  fifo_count_o;
   logic        pipe_stall_o;

   int checks = 0;
   int errors = 0;

   dtcore32_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .pipe_wb_valid_i(pipe_wb_valid_i), .pipe_wb_rd_i(pipe_wb_rd_i),
      .pipe_wb_data_i(pipe_wb_data_i),
      .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
      .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
      .regfile_wr_en_o(regfile_wr_en_o), .dest_reg_o(dest_reg_o),
      .reg_wr_data_o(reg_wr_data_o), .pending_mask_o(pending_mask_o),
      .fifo_count_o(fifo_count_o), .pipe_stall_o(pipe_stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
      pipe_wb_valid_i = v; pipe_wb_rd_i = rd; pipe_wb_data_i = d;
   endtask

   task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lu_valid_i = v; lu_rd_i = rd; lu_data_i = d;
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
      chk({tag, ".en"},   32'(regfile_wr_en_o), 32'(en));
      chk({tag, ".rd"},   32'(dest_reg_o),      32'(rd));
      chk({tag, ".data"}, reg_wr_data_o,        d);
   endtask

   initial begin
      rst_ni = 1'b0;
      pipe(1'b0, 5'd0, 32'h0);
      lu(1'b0, 5'd0, 32'h0);
      step(); step();
      chk_wr("rst0", 1'b0, 5'd0, 32'h0);
      chk("rst0.count", 32'(fifo_count_o), 32'd0);
      chk("rst0.mask",  pending_mask_o, 32'h0);
      chk("rst0.stall", 32'(pipe_stall_o), 32'd0);
      chk("rst0.ready", 32'(lu_ready_o), 32'd1);
      rst_ni = 1'b1;
      step();

      // single long-latency result, pipeline idle; no same-cycle bypass
      lu(1'b1, 5'd5, 32'hDEADBEEF);
      step();
      lu(1'b0, 5'd0, 32'h0);
      chk("t1.mask",  pending_mask_o, 32'h0000_0020);
      chk("t1.count", 32'(fifo_count_o), 32'd1);
      chk("t1.nobyp", 32'(regfile_wr_en_o), 32'd0);
      step();
      chk_wr("t1.drain", 1'b1, 5'd5, 32'hDEADBEEF);
      chk("t1.mask0",  pending_mask_o, 32'h0);
      chk("t1.count0", 32'(fifo_count_o), 32'd0);
      step();
      chk_wr("t1.idle", 1'b0, 5'd5, 32'hDEADBEEF);

      // pipeline busy on x3 while four results fill the FIFO
      for (int i = 0; i < 4; i++) begin
         pipe(1'b1, 5'd3, 32'h300 + i);
         lu(1'b1, 5'(7 + i), 32'h1000 + i);
         step();
         chk_wr("t2.pipe", 1'b1, 5'd3, 32'h300 + i);
      end
      chk("t2.ready",  32'(lu_ready_o), 32'd0);
      chk("t2.count",  32'(fifo_count_o), 32'd4);
      chk("t2.mask",   pending_mask_o, 32'h0000_0780);
      // full FIFO must refuse a further result
      lu(1'b1, 5'd11, 32'h2000);
      step();
      chk("t2.full",   32'(fifo_count_o), 32'd4);
      chk("t2.mask11", pending_mask_o, 32'h0000_0780);
      lu(1'b0, 5'd0, 32'h0);
      pipe(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_wr("t2.drain", 1'b1, 5'(7 + i), 32'h1000 + i);
      end
      chk("t2.empty", 32'(fifo_count_o), 32'd0);
      chk("t2.mask0", pending_mask_o, 32'h0);

      // x0 on both sources: handshake completes, nothing written or stored
      lu(1'b1, 5'd0, 32'h5555);
      pipe(1'b1, 5'd0, 32'h6666);
      chk("t3.ready", 32'(lu_ready_o), 32'd1);
      step();
      chk("t3.wr",    32'(regfile_wr_en_o), 32'd0);
      chk("t3.count", 32'(fifo_count_o), 32'd0);
      chk("t3.mask",  pending_mask_o, 32'h0);
      lu(1'b0, 5'd0, 32'h0);
      pipe(1'b0, 5'd0, 32'h0);
      step();

      // simultaneous push and pop at count 2
      pipe(1'b1, 5'd3, 32'h33);
      lu(1'b1, 5'd12, 32'hAAAA_0001);
      step();
      lu(1'b1, 5'd13, 32'hAAAA_0002);
      step();
      chk("t4.count2", 32'(fifo_count_o), 32'd2);
      pipe(1'b0, 5'd0, 32'h0);
      lu(1'b1, 5'd14, 32'hAAAA_0003);
      step();
      lu(1'b0, 5'd0, 32'h0);
      chk_wr("t4.head", 1'b1, 5'd12, 32'hAAAA_0001);
      chk("t4.count", 32'(fifo_count_o), 32'd2);
      chk("t4.mask",  pending_mask_o, 32'h0000_6000);
      step();
      chk_wr("t4.d1", 1'b1, 5'd13, 32'hAAAA_0002);
      step();
      chk_wr("t4.d2", 1'b1, 5'd14, 32'hAAAA_0003);
      chk("t4.count0", 32'(fifo_count_o), 32'd0);

      // guard off: pipeline starves the FIFO, stall never raised
      pipe(1'b1, 5'd4, 32'h44);
      lu(1'b1, 5'd21, 32'hBEEF_0021);
      step();
      lu(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("t5.stall", 32'(pipe_stall_o), 32'd0);
      end
      chk("t5.held", 32'(fifo_count_o), 32'd1);
      chk_wr("t5.pipe", 1'b1, 5'd4, 32'h44);
      // pipeline write to x0 frees the port for the FIFO
      pipe(1'b1, 5'd0, 32'h99);
      step();
      chk_wr("t5.x0free", 1'b1, 5'd21, 32'hBEEF_0021);
      pipe(1'b0, 5'd0, 32'h0);
      step();

      // reset with three results buffered discards them
      pipe(1'b1, 5'd3, 32'h77);
      for (int i = 0; i < 3; i++) begin
         lu(1'b1, 5'(24 + i), 32'h2400 + i);
         step();
      end
      lu(1'b0, 5'd0, 32'h0);
      chk("t6.count3", 32'(fifo_count_o), 32'd3);
      chk("t6.mask3",  pending_mask_o, 32'h0700_0000);
      rst_ni = 1'b0;
      step();
      chk_wr("t6.rst", 1'b0, 5'd0, 32'h0);
      chk("t6.count", 32'(fifo_count_o), 32'd0);
      chk("t6.mask",  pending_mask_o, 32'h0);
      rst_ni = 1'b1;
      pipe(1'b0, 5'd0, 32'h0);
      step();
      chk("t6.noret", 32'(regfile_wr_en_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
